// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter chain: default sizes and the
// accumulator width rule used by the decimator.
package fir_pkg;

  localparam int FIR_WIDTH      = 8;
  localparam int FIR_DECIM      = 4;
  localparam int FIR_FIFO_DEPTH = 4;

  // A sum of decim unsigned width-bit samples needs $clog2(decim) extra bits.
  function automatic int acc_width(input int width, input int decim);
    return width + $clog2(decim);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop frees the slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; rdata is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fir_decimator.sv
// Accumulate-and-dump decimator: sums each group of DECIM valid samples and
// queues the sum for a valid/ready consumer, flagging sums lost to a full FIFO.
module fir_decimator
  import fir_pkg::*;
#(
  parameter  int WIDTH     = FIR_WIDTH,
  parameter  int DECIM     = FIR_DECIM,
  parameter  int DEPTH     = FIR_FIFO_DEPTH,
  localparam int OUT_WIDTH = acc_width(WIDTH, DECIM)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   valid_in,
  output logic [OUT_WIDTH-1:0]   data_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int              PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] LAST = PH_W'(DECIM - 1);

  logic [PH_W-1:0]      phase;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] sum;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic                 full;

  assign sum       = acc + OUT_WIDTH'(data_in);
  assign push      = valid_in && (phase == LAST);
  assign valid_out = !empty;
  assign pop       = valid_out && ready_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      acc   <= '0;
    end else if (clear) begin
      phase <= '0;
      acc   <= '0;
    end else if (valid_in) begin
      if (phase == LAST) begin
        phase <= '0;
        acc   <= '0;
      end else begin
        phase <= phase + PH_W'(1);
        acc   <= sum;
      end
    end
  end

  // A same-edge pop makes room, so only an unrelieved full FIFO loses the sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     overflow <= 1'b0;
    else if (clear)                   overflow <= 1'b0;
    else if (push && full && !pop)    overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push),
    .pop     (pop),
    .wdata   (sum),
    .rdata   (data_out),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator at default parameters: directed sample
// groups with hand-computed sums, plus direct checks of level/overflow/timing.
module tb_fir_decimator;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic [7:0] data_in;
  logic       valid_in;
  logic [9:0] data_out;
  logic       valid_out;
  logic       ready_in;
  logic [2:0] level;
  logic       overflow;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [9:0] exp_q[$];

  fir_decimator dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && valid_out === 1'b1 && ready_in === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {22'd0, data_out}, 32'hFFFF_FFFF);
      end else begin
        chk("scoreboard_data", {22'd0, data_out}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic sample(input logic [7:0] d);
    valid_in = 1'b1;
    data_in  = d;
    @(posedge clk); #1;
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
    #12;
    chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
    chk("reset_level", {29'd0, level}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    chk("reset_data_out", {22'd0, data_out}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1,2,3,4 back to back -> 10
    ready_in = 1'b1;
    exp_q.push_back(10'd10);
    sample(8'd1); sample(8'd2); sample(8'd3);
    chk("t1_no_early_valid", {31'd0, valid_out}, 32'd0);
    sample(8'd4);
    chk("t1_valid_latency", {31'd0, valid_out}, 32'd1);
    chk("t1_data_out", {22'd0, data_out}, 32'd10);
    idle(1);
    chk("t1_level_drained", {29'd0, level}, 32'd0);
    chk("t1_valid_low", {31'd0, valid_out}, 32'd0);

    // 255 x4 with two idle cycles between samples -> 1020
    exp_q.push_back(10'd1020);
    for (int i = 0; i < 3; i++) begin
      sample(8'd255);
      idle(2);
      chk("t2_no_early_valid", {31'd0, valid_out}, 32'd0);
    end
    sample(8'd255);
    chk("t2_valid", {31'd0, valid_out}, 32'd1);
    chk("t2_data_out", {22'd0, data_out}, 32'd1020);
    idle(1);

    // Stalled consumer: 20 ones -> 5 sums, 5th dropped
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(10'd4);
    for (int i = 0; i < 16; i++) sample(8'd1);
    chk("t3_level_full", {29'd0, level}, 32'd4);
    chk("t3_no_overflow_yet", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) sample(8'd1);
    chk("t3_level_after_drop", {29'd0, level}, 32'd4);
    chk("t3_overflow_set", {31'd0, overflow}, 32'd1);
    ready_in = 1'b1;
    idle(6);
    chk("t3_level_drained", {29'd0, level}, 32'd0);
    chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Clear, then push into a full FIFO with a same-edge pop
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("t4_clear_overflow", {31'd0, overflow}, 32'd0);
    ready_in = 1'b0;
    for (int g = 1; g <= 4; g++) begin
      exp_q.push_back(10'(4 * g));
      for (int i = 0; i < 4; i++) sample(8'(g));
    end
    chk("t4_level_full", {29'd0, level}, 32'd4);
    exp_q.push_back(10'd20);
    sample(8'd5); sample(8'd5); sample(8'd5);
    ready_in = 1'b1;
    sample(8'd5);
    chk("t4_level_held", {29'd0, level}, 32'd4);
    chk("t4_no_overflow", {31'd0, overflow}, 32'd0);
    idle(6);
    chk("t4_level_drained", {29'd0, level}, 32'd0);

    // 5,6 then clear (sample discarded) then 1,1,1,1 -> 4
    sample(8'd5); sample(8'd6);
    clear = 1'b1;
    sample(8'd9);
    clear = 1'b0;
    exp_q.push_back(10'd4);
    sample(8'd1); sample(8'd1);
    chk("t5_no_output_after_2", {31'd0, valid_out}, 32'd0);
    sample(8'd1);
    chk("t5_no_output_after_3", {31'd0, valid_out}, 32'd0);
    sample(8'd1);
    chk("t5_valid", {31'd0, valid_out}, 32'd1);
    chk("t5_data_out", {22'd0, data_out}, 32'd4);
    idle(2);

    // Asynchronous reset mid-group with two queued sums
    ready_in = 1'b0;
    for (int i = 0; i < 8; i++) sample(8'd1);
    sample(8'd3); sample(8'd3);
    chk("t6_level_before_reset", {29'd0, level}, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_reset_valid_out", {31'd0, valid_out}, 32'd0);
    chk("t6_reset_data_out", {22'd0, data_out}, 32'd0);
    chk("t6_reset_level", {29'd0, level}, 32'd0);
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b1;
    exp_q.push_back(10'd8);
    sample(8'd2); sample(8'd2); sample(8'd2);
    chk("t6_no_early_valid", {31'd0, valid_out}, 32'd0);
    sample(8'd2);
    chk("t6_valid", {31'd0, valid_out}, 32'd1);
    chk("t6_data_out", {22'd0, data_out}, 32'd8);
    idle(3);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
